reorder_buffer: RTL
===================

# reorder_buffer

In-order retirement stage that sits directly upstream of the architectural register file. It allocates a 4-bit rename tag per issued instruction and captures results broadcast on the CDB. Each cycle it retires at most the oldest completed entry, driving the register file's commit port. On a mispredicted branch reaching the head, it raises the register-file flush and supplies the redirect PC.

## Interface
- `ROB_DEPTH_LOG`, default 4: log2 of entry count; depth 16 matches the 4-bit rename tags.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global enable; when low, all state and outputs hold.
- `alloc_valid` in 1: issue requests an entry this cycle.
- `alloc_has_rd` in 1: instruction writes a destination register.
- `alloc_rd` in 5: destination register index.
- `alloc_is_branch` in 1: entry is a conditional branch.
- `alloc_pred_taken` in 1: predictor's direction for that branch.
- `alloc_alt_pc` in 32: PC to fetch if the prediction proves wrong.
- `alloc_id` out 4: combinational; equals the tail pointer, i.e. the tag the next allocation receives.
- `rob_full` out 1: combinational; high when count == 16.
- `cdb_valid` in 1: result broadcast valid.
- `cdb_id` in 4: tag of the completing entry.
- `cdb_value` in 32: result value.
- `cdb_taken` in 1: actual branch direction (ignored for non-branches).
- `register_update_flag` out 1: one-cycle commit pulse to the register file.
- `register_commit_dest` out 5: committed rd.
- `register_commit_value` out 32: committed value.
- `rename_of_commit_ins` out 4: tag of the committed entry.
- `register_flush` out 1: one-cycle flush pulse to the register file and RS.
- `flush_pc` out 32: redirect PC, valid while `register_flush` is high.

## Operation
- Circular buffer with a head pointer, a tail pointer and a 5-bit count. Both pointers wrap modulo 16.
- Each entry stores: busy, ready, has_rd, rd, value, is_branch, pred_taken, taken, alt_pc.
- **Allocate**: when `alloc_valid` is high and `rob_full` is low, write entry[tail] with busy=1, ready=0, then increment tail. `alloc_valid` while full is dropped; issue must hold off.
- **Writeback**: when `cdb_valid` is high and entry[cdb_id] is busy, set ready=1 and store value and taken. A CDB write to a non-busy entry is ignored.
- **Commit**: if entry[head] is busy and ready (stored flag only), retire it, clear busy and increment head.
  - Non-branch with has_rd=1 and rd≠0: pulse `register_update_flag` with dest, value and tag.
  - Non-branch with rd=0 or has_rd=0: retire with no pulse.
  - Branch with taken==pred_taken: retire with no pulse.
  - Branch with taken≠pred_taken: pulse `register_flush`, set `flush_pc`=alt_pc, and clear all busy bits, head, tail and count in the same edge.
- Count update: +1 on accepted allocation, −1 on commit; both together leave it unchanged.
- In a flush cycle, the allocation and CDB write are discarded.
- `register_update_flag` and `register_flush` are low on every edge with no corresponding event.

## Timing
- Reset values: all outputs 0 (`register_update_flag`, `register_commit_dest`, `register_commit_value`, `rename_of_commit_ins`, `register_flush`, `flush_pc`). Head=tail=count=0, all busy=0, so `rob_full`=0 and `alloc_id`=0.
- Allocation: the tag is visible on `alloc_id` in the request cycle; the entry is occupied after that edge.
- CDB sampled at edge k means commit outputs are asserted after edge k+1. A same-cycle CDB write to the head does not retire at edge k.
- Throughput: one commit per cycle.
- Full boundary: allocation and commit in the same cycle while count==16 leaves the allocation rejected; `rob_full` uses the pre-edge count.
- `rdy` low freezes pointers, entries and all registered outputs. A pulse pending when `rdy` drops is therefore seen exactly once by the register file, which also stalls on `rdy`.
- `rst` asserted mid-operation clears everything asynchronously; in-flight pulses drop immediately.

## Configuration
- `ROB_BYPASS_EN` defined: adds ports `query_id_1`, `query_id_2` (in, 4) and `query_ready_1`, `query_ready_2` (out, 1), `query_value_1`, `query_value_2` (out, 32).
  - Combinational lookup: ready = busy && ready of that entry, plus a same-cycle CDB hit on that id with `cdb_value` forwarded.
  - Lets dispatch read completed but uncommitted results.
- `ROB_BYPASS_EN` undefined: these ports do not exist, and operands wait for commit or CDB broadcast.

## Test plan
- Reset → all outputs 0, `alloc_id`=0, `rob_full`=0; issue 3 allocs with rd=5,6,7 → `alloc_id` reads 0,1,2.
- CDB id 1, value 0x22, then id 0, value 0x11 → commits in order: tag 0 / rd 5 / 0x11, then tag 1 / rd 6 / 0x22 on consecutive cycles.
- 16 allocs → `rob_full`=1; 17th alloc ignored. Commit one with an alloc in the same cycle → alloc rejected; next cycle it succeeds and gets tag 0 after wrap.
- Branch pred_taken=1, alt_pc 0x1000, CDB taken=0 → one-cycle `register_flush`=1, `flush_pc`=0x1000, then count=0, `alloc_id`=0.
- Entry with rd=0 ready → retires with `register_update_flag`=0; `rdy` low for 3 cycles during a pending commit pulse → outputs hold, no extra pulse.
- With `ROB_BYPASS_EN`: query a ready entry holding 0xABCD → `query_ready`=1, `query_value`=0xABCD; same-cycle CDB hit → forwarded value.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement stage feeding the architectural register file.
// Optional macro ROB_BYPASS_EN adds combinational operand query ports.
module reorder_buffer #(
   parameter int unsigned ROB_DEPTH_LOG = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     alloc_valid,
   input  logic                     alloc_has_rd,
   input  logic [4:0]               alloc_rd,
   input  logic                     alloc_is_branch,
   input  logic                     alloc_pred_taken,
   input  logic [31:0]              alloc_alt_pc,
   output logic [ROB_DEPTH_LOG-1:0] alloc_id,
   output logic                     rob_full,
   input  logic                     cdb_valid,
   input  logic [ROB_DEPTH_LOG-1:0] cdb_id,
   input  logic [31:0]              cdb_value,
   input  logic                     cdb_taken,
`ifdef ROB_BYPASS_EN
   input  logic [ROB_DEPTH_LOG-1:0] query_id_1,
   input  logic [ROB_DEPTH_LOG-1:0] query_id_2,
   output logic                     query_ready_1,
   output logic                     query_ready_2,
   output logic [31:0]              query_value_1,
   output logic [31:0]              query_value_2,
`endif
   output logic                     register_update_flag,
   output logic [4:0]               register_commit_dest,
   output logic [31:0]              register_commit_value,
   output logic [ROB_DEPTH_LOG-1:0] rename_of_commit_ins,
   output logic                     register_flush,
   output logic [31:0]              flush_pc
);

   localparam int unsigned DEPTH = 1 << ROB_DEPTH_LOG;
   localparam int unsigned CW    = ROB_DEPTH_LOG + 1;

   typedef logic [ROB_DEPTH_LOG-1:0] ptr_t;

   logic        busy_q   [DEPTH];
   logic        busy_d   [DEPTH];
   logic        ready_q  [DEPTH];
   logic        ready_d  [DEPTH];
   logic        has_rd_q [DEPTH];
   logic        has_rd_d [DEPTH];
   logic [4:0]  rd_q     [DEPTH];
   logic [4:0]  rd_d     [DEPTH];
   logic [31:0] value_q  [DEPTH];
   logic [31:0] value_d  [DEPTH];
   logic        is_br_q  [DEPTH];
   logic        is_br_d  [DEPTH];
   logic        pred_q   [DEPTH];
   logic        pred_d   [DEPTH];
   logic        taken_q  [DEPTH];
   logic        taken_d  [DEPTH];
   logic [31:0] alt_pc_q [DEPTH];
   logic [31:0] alt_pc_d [DEPTH];

   ptr_t          head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic        upd_q, upd_d, flush_q, flush_d;
   logic [4:0]  dest_q, dest_d;
   logic [31:0] val_q, val_d, fpc_q, fpc_d;
   ptr_t        tag_q, tag_d;

   logic alloc_ok, commit, mispredict;

   assign alloc_id   = tail_q;
   assign rob_full   = (count_q == CW'(DEPTH));
   assign alloc_ok   = alloc_valid && !rob_full;
   assign commit     = busy_q[head_q] && ready_q[head_q];
   assign mispredict = commit && is_br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

   assign register_update_flag  = upd_q;
   assign register_commit_dest  = dest_q;
   assign register_commit_value = val_q;
   assign rename_of_commit_ins  = tag_q;
   assign register_flush        = flush_q;
   assign flush_pc              = fpc_q;

   always_comb begin
      busy_d   = busy_q;
      ready_d  = ready_q;
      has_rd_d = has_rd_q;
      rd_d     = rd_q;
      value_d  = value_q;
      is_br_d  = is_br_q;
      pred_d   = pred_q;
      taken_d  = taken_q;
      alt_pc_d = alt_pc_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      upd_d    = 1'b0;
      dest_d   = dest_q;
      val_d    = val_q;
      tag_d    = tag_q;
      flush_d  = 1'b0;
      fpc_d    = fpc_q;
      // A mispredict at the head squashes everything, including this cycle's alloc/CDB
      if (mispredict) begin
         busy_d  = '{default: 1'b0};
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         flush_d = 1'b1;
         fpc_d   = alt_pc_q[head_q];
      end else begin
         if (cdb_valid && busy_q[cdb_id]) begin
            ready_d[cdb_id] = 1'b1;
            value_d[cdb_id] = cdb_value;
            taken_d[cdb_id] = cdb_taken;
         end
         if (alloc_ok) begin
            busy_d[tail_q]   = 1'b1;
            ready_d[tail_q]  = 1'b0;
            has_rd_d[tail_q] = alloc_has_rd;
            rd_d[tail_q]     = alloc_rd;
            is_br_d[tail_q]  = alloc_is_branch;
            pred_d[tail_q]   = alloc_pred_taken;
            alt_pc_d[tail_q] = alloc_alt_pc;
            tail_d           = tail_q + ptr_t'(1);
         end
         if (commit) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + ptr_t'(1);
            if (!is_br_q[head_q] && has_rd_q[head_q] && (rd_q[head_q] != 5'd0)) begin
               upd_d  = 1'b1;
               dest_d = rd_q[head_q];
               val_d  = value_q[head_q];
               tag_d  = head_q;
            end
         end
         case ({alloc_ok, commit})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '{default: 1'b0};
         ready_q <= '{default: 1'b0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         upd_q   <= 1'b0;
         dest_q  <= '0;
         val_q   <= '0;
         tag_q   <= '0;
         flush_q <= 1'b0;
         fpc_q   <= '0;
      end else if (rdy) begin
         busy_q  <= busy_d;
         ready_q <= ready_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         upd_q   <= upd_d;
         dest_q  <= dest_d;
         val_q   <= val_d;
         tag_q   <= tag_d;
         flush_q <= flush_d;
         fpc_q   <= fpc_d;
      end
   end

   // Payload is qualified by busy, so it needs no reset
   always_ff @(posedge clk) begin
      if (rdy) begin
         has_rd_q <= has_rd_d;
         rd_q     <= rd_d;
         value_q  <= value_d;
         is_br_q  <= is_br_d;
         pred_q   <= pred_d;
         taken_q  <= taken_d;
         alt_pc_q <= alt_pc_d;
      end
   end

`ifdef ROB_BYPASS_EN
   always_comb begin
      query_ready_1 = busy_q[query_id_1] && ready_q[query_id_1];
      query_value_1 = value_q[query_id_1];
      if (cdb_valid && busy_q[query_id_1] && (cdb_id == query_id_1)) begin
         query_ready_1 = 1'b1;
         query_value_1 = cdb_value;
      end
      query_ready_2 = busy_q[query_id_2] && ready_q[query_id_2];
      query_value_2 = value_q[query_id_2];
      if (cdb_valid && busy_q[query_id_2] && (cdb_id == query_id_2)) begin
         query_ready_2 = 1'b1;
         query_value_2 = cdb_value;
      end
   end
`endif

endmodule
